// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues word loads/stores over a req/ack bus,
// stalls upstream while an access is outstanding, and feeds the MEM/WB register.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_out_m,
  input  logic [31:0] write_data_m,
  input  logic [4:0]  writereg_m,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic        MemWrite_in,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] alu_res,
  output logic [31:0] mem_data,
  output logic [4:0]  writereg,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic        stall_m,
  output logic        addr_err,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state_reg, state_next;
  logic          mem_req_reg, mem_we_reg;
  logic [31:0]   mem_addr_reg, mem_wdata_reg;
  logic [31:0]   alu_reg, data_reg;
  logic [4:0]    wr_reg;
  logic          rw_reg, mtr_reg, to_reg;
  logic [CW-1:0] cnt_reg;

  logic mem_op, misaligned, start, timeout_hit;

  assign mem_op      = MemtoReg_in | MemWrite_in;
  assign misaligned  = alu_out_m[1:0] != 2'b00;
  assign start       = (state_reg == IDLE) && mem_op && !misaligned;
  assign timeout_hit = (state_reg == WAIT) && !mem_ack && (cnt_reg == TO_LAST);

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = WAIT;
      WAIT:    if (mem_ack || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus registers and the instruction context held across the access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      alu_reg       <= '0;
      data_reg      <= '0;
      wr_reg        <= '0;
      rw_reg        <= 1'b0;
      mtr_reg       <= 1'b0;
      to_reg        <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= MemWrite_in;
            mem_addr_reg  <= {alu_out_m[31:2], 2'b00};
            mem_wdata_reg <= write_data_m;
            alu_reg       <= alu_out_m;
            wr_reg        <= writereg_m;
            rw_reg        <= RegWrite_in;
            mtr_reg       <= MemtoReg_in;
            to_reg        <= 1'b0;
            cnt_reg       <= '0;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            data_reg    <= mtr_reg ? mem_rdata : 32'h0;
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
          end else if (cnt_reg == TO_LAST) begin
            data_reg    <= 32'h0;
            to_reg      <= 1'b1;
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE:    to_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  // Outputs to MEM/WB and the hazard unit; stalled cycles always inject a bubble
  always_comb begin
    alu_res      = alu_out_m;
    writereg     = writereg_m;
    RegWrite_out = 1'b0;
    MemtoReg_out = 1'b0;
    mem_data     = 32'h0;
    stall_m      = 1'b0;
    addr_err     = 1'b0;
    bus_err      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!mem_op)         RegWrite_out = RegWrite_in;
        else if (misaligned) addr_err     = 1'b1;
        else                 stall_m      = 1'b1;
      end
      WAIT: begin
        alu_res  = alu_reg;
        writereg = wr_reg;
        stall_m  = 1'b1;
      end
      DONE: begin
        alu_res      = alu_reg;
        writereg     = wr_reg;
        MemtoReg_out = mtr_reg;
        mem_data     = data_reg;
        RegWrite_out = rw_reg & ~to_reg;
        bus_err      = to_reg;
      end
      default: ;
    endcase
    if (!rst_n) begin
      stall_m      = 1'b0;
      RegWrite_out = 1'b0;
      addr_err     = 1'b0;
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, between the EX/MEM register and the MEM/WB register. It drives word loads and stores onto a variable-latency data-memory bus through a req/ack handshake. It stalls the upstream pipeline while an access is outstanding, and presents ALU result, load data, destination register and WB control to the MEM/WB register. Non-memory instructions pass through with no added latency.

## Interface
- TIMEOUT, default 16: max cycles in WAIT without mem_ack before the access is abandoned (≥1).
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_out_m  in  32  ALU result from EX/MEM; the byte address for loads and stores.
- write_data_m  in  32  store data from EX/MEM.
- writereg_m  in  5  destination register from EX/MEM.
- RegWrite_in, MemtoReg_in, MemWrite_in  in  1 each  control bits from EX/MEM (MemtoReg_in=1 means load).
- mem_rdata  in  32  read data; valid only when mem_ack=1.
- mem_ack  in  1  one-cycle completion pulse from memory.
- mem_req, mem_we  out  1 each  registered bus request and write enable.
- mem_addr, mem_wdata  out  32 each  registered bus address and store data.
- alu_res, mem_data  out  32 each  to MEM/WB.
- writereg  out  5  to MEM/WB.
- RegWrite_out, MemtoReg_out  out  1 each  to MEM/WB.
- stall_m  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle.
- addr_err  out  1  misaligned-access flag, one cycle.
- bus_err  out  1  timeout flag, one cycle.

## Operation
- FSM states: IDLE, WAIT, DONE.
- Memory op = MemtoReg_in | MemWrite_in.
- **IDLE**
  - Non-memory op: alu_res=alu_out_m, writereg=writereg_m, RegWrite_out=RegWrite_in, MemtoReg_out=0, mem_data=0, stall_m=0. All combinational.
  - Memory op with alu_out_m[1:0]≠0: addr_err=1, no bus access, RegWrite_out=0, stall_m=0, remain IDLE.
  - Aligned memory op: stall_m=1, RegWrite_out=0 (bubble into WB).
    - At the edge, latch mem_addr={alu_out_m[31:2],2'b00}, mem_wdata=write_data_m and mem_we=MemWrite_in.
    - Also latch writereg_m, RegWrite_in, MemtoReg_in and alu_out_m internally.
    - Set mem_req=1, clear timeout counter, go to WAIT.
- **WAIT**
  - stall_m=1, RegWrite_out=0.
  - mem_req, mem_addr, mem_we and mem_wdata hold stable until the ack edge.
  - mem_ack=1: capture mem_rdata (loads only; stores capture 0), drop mem_req and mem_we, go to DONE.
  - No ack: counter increments. On the edge where counter reaches TIMEOUT-1 with no ack:
    - drop mem_req;
    - set captured data=0 and an internal timeout flag;
    - go to DONE.
- **DONE**
  - stall_m=0.
  - Outputs come from latched values: alu_res, writereg, MemtoReg_out, and mem_data=captured data.
  - RegWrite_out=latched RegWrite, or 0 if the timeout flag is set.
  - bus_err=timeout flag.
  - Next edge: go to IDLE and clear the flag. Upstream advances on this same edge.
- mem_ack outside WAIT is ignored.
- Async reset mid-access drops mem_req immediately and abandons the access.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, bus_err=0, latched regs=0.
- While rst_n=0: stall_m=0, RegWrite_out=0, addr_err=0.
- Non-memory op: 0 added cycles.
- Aligned access: cycle 0 IDLE with stall; mem_req visible from cycle 1.
  - Ack in cycle k≥1 gives DONE in cycle k+1.
  - Total stall = k+1 cycles (minimum 2).
- Timeout: mem_req high for TIMEOUT cycles, then DONE.
- Back-to-back memory ops: the second is seen in IDLE on the cycle after DONE. Memory ops are never overlapped.
- Every stalled cycle delivers a bubble (RegWrite_out=0) to MEM/WB, because MEM/WB has no enable.

## Test plan
- Reset, then add with alu_out_m=0x10, writereg_m=8, RegWrite_in=1 -> same cycle alu_res=0x10, writereg=8, RegWrite_out=1, stall_m=0, mem_req=0.
- Load at 0x100, ack in the first WAIT cycle with rdata=0xDEADBEEF:
  - stall_m=1 for 2 cycles, mem_addr=0x100;
  - DONE cycle has mem_data=0xDEADBEEF, MemtoReg_out=1, RegWrite_out=1, stall_m=0.
- Store of 0xCAFEF00D to 0x204, ack after 4 WAIT cycles:
  - mem_we=1 and mem_wdata=0xCAFEF00D stable for 4 cycles;
  - stall 5 cycles, RegWrite_out=0 throughout.
- Load at 0x102 -> addr_err=1 for one cycle, mem_req stays 0, RegWrite_out=0, stall_m=0.
- TIMEOUT=4, load with no ack:
  - mem_req high exactly 4 cycles;
  - DONE has bus_err=1, mem_data=0, RegWrite_out=0;
  - a late mem_ack in IDLE has no effect.
- rst_n pulsed low during WAIT -> mem_req=0 and stall_m=0 asynchronously; after release, state IDLE and the next op proceeds normally.
